// File: rtl/rtc_bus_responder.sv
// Runs one multiplexed address/data cycle on the RTC parallel bus per sequencer request
// and keeps a 16-entry shadow file of captured read bytes.
module rtc_bus_responder #(
    parameter int TPH = 4,
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dir,
    input  logic [3:0] dir_reg,
    input  logic [7:0] dato,
    input  logic       escritura,
    input  logic       lectura,
    input  logic       write,
    output logic       fin,
    output logic       busy,
    output logic [7:0] rdata,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_data
);

    typedef enum logic [3:0] {
        IDLE, A_SU, A_ST, A_HD, D_SU, D_ST, D_HD, DONE, RECOV
    } state_t;

    localparam logic [7:0] LAST_PH  = 8'(TPH - 1);
    localparam logic [7:0] LAST_GAP = 8'(GAP - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] addr_q, data_q;
    logic [3:0] idx_q;
    logic       store_q, is_wr_q;
    logic [7:0] shadow [16];

    logic       accept, phase_end, in_phase;
    logic       cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d, fin_d;
    logic [7:0] ad_out_d;

    assign accept    = (state == IDLE) && (escritura || lectura);
    assign phase_end = (cnt == LAST_PH);
    assign in_phase  = (state inside {A_SU, A_ST, A_HD, D_SU, D_ST, D_HD});
    assign rd_data   = shadow[rd_idx];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (in_phase)
            cnt_next = phase_end ? 8'd0 : cnt + 8'd1;
        case (state)
            IDLE: if (accept) begin
                state_next = A_SU;
                cnt_next   = 8'd0;
            end
            A_SU: if (phase_end) state_next = A_ST;
            A_ST: if (phase_end) state_next = A_HD;
            A_HD: if (phase_end) state_next = D_SU;
            D_SU: if (phase_end) state_next = D_ST;
            D_ST: if (phase_end) state_next = D_HD;
            D_HD: if (phase_end) state_next = DONE;
            DONE: begin
                state_next = RECOV;
                cnt_next   = 8'd0;
            end
            RECOV: begin
                if (cnt == LAST_GAP) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Bus pins are a registered image of the current state, so every pin changes on a clock edge
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'd0;
        fin_d    = 1'b0;
        case (state)
            A_SU, A_ST, A_HD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
                wr_n_d   = (state != A_ST);
            end
            D_SU, D_ST, D_HD: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                if (is_wr_q) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_q;
                    wr_n_d   = (state != D_ST);
                end else begin
                    rd_n_d = (state != D_ST);
                end
            end
            DONE: fin_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b0;
            ad_oe   <= 1'b0;
            ad_out  <= 8'd0;
            fin     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 8'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            idx_q   <= 4'd0;
            store_q <= 1'b0;
            is_wr_q <= 1'b0;
            for (int i = 0; i < 16; i++)
                shadow[i] <= 8'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            cs_n   <= cs_n_d;
            rd_n   <= rd_n_d;
            wr_n   <= wr_n_d;
            a_d    <= a_d_d;
            ad_oe  <= ad_oe_d;
            ad_out <= ad_out_d;
            fin    <= fin_d;
            busy   <= (state_next != IDLE);
            if (accept) begin
                addr_q  <= dir;
                data_q  <= dato;
                idx_q   <= dir_reg;
                store_q <= write;
                is_wr_q <= escritura;
            end
            // Sample on the last strobe cycle, while rd_n is still low at the pin
            if (state == D_ST && phase_end && !is_wr_q)
                rdata <= ad_in;
            if (state == DONE && store_q && !is_wr_q)
                shadow[idx_q] <= rdata;
        end
    end

endmodule
